game_flow_ctrl: RTL and testbench

- Top-level game sequencer between the joystick/button inputs, proc_skeleton and vga_controller.
- Debounces start and pause buttons and runs the screen state machine (title / play / pause / death / game over).
- Tracks the shared lives count and drives screenReg, gameplay, the processor stall and respawn strobes, and the pacman_mouth animation toggle consumed by vga_controller.

---
 rtl/game_flow_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: button conditioning, screen sequencing, lives tracking and
// mouth animation for the game top level.
// Build option: define ATTRACT_TIMEOUT_EN to make GAMEOVER return to TITLE on its
// own after ATTRACT_CYCLES idle cycles.
module game_flow_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter int unsigned DEATH_HOLD_CYCLES = 100000000,
  parameter int unsigned MOUTH_PERIOD      = 6250000,
  parameter int unsigned LIVES             = 3
`ifdef ATTRACT_TIMEOUT_EN
  , parameter int unsigned ATTRACT_CYCLES  = 500000000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       player0_dead,
  input  logic       player1_dead,
  output logic [2:0] screenReg,
  output logic       gameplay,
  output logic       proc_stall,
  output logic       respawn,
  output logic [1:0] lives_left,
  output logic       pacman_mouth
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W  = $clog2(DEATH_HOLD_CYCLES + 1);
  localparam int unsigned MOUTH_W = $clog2(MOUTH_PERIOD + 1);
`ifdef ATTRACT_TIMEOUT_EN
  localparam int unsigned ATT_W   = $clog2(ATTRACT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_TITLE    = 3'd0,
    S_PLAY     = 3'd1,
    S_PAUSE    = 3'd2,
    S_DEATH    = 3'd3,
    S_GAMEOVER = 3'd4
  } state_t;

  // Bit 0 = start, bit 1 = pause.
  logic [1:0]            btn_s1_q, btn_s2_q;
  logic [1:0]            dead_s1_q, dead_s2_q;
  logic [1:0]            init_q, init_d;
  logic [1:0]            db_q, db_d;
  logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]            press_c;
  logic                  dead_any_c;

  state_t                state_q, state_d;
  logic                  gameplay_q, gameplay_d;
  logic                  stall_q, stall_d;
  logic                  respawn_q, respawn_d;
  logic [1:0]            lives_q, lives_d;
  logic                  mouth_q, mouth_d;
  logic [MOUTH_W-1:0]    mcnt_q, mcnt_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
`ifdef ATTRACT_TIMEOUT_EN
  logic [ATT_W-1:0]      att_q, att_d;
`endif

  assign dead_any_c = dead_s2_q[0] | dead_s2_q[1];

  // Debouncers: seed from the synchronizer after reset, then require a stable mismatch.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press_c  = '0;
    init_d   = (init_q == 2'd2) ? init_q : init_q + 2'd1;
    if (init_q != 2'd2) begin
      db_d = btn_s1_q;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s2_q[i] != db_q[i]) begin
          if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_d[i]    = btn_s2_q[i];
            press_c[i] = btn_s2_q[i];
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
          end
        end
      end
    end
  end

  // Screen FSM next state, lives, hold/mouth counters and registered outputs.
  always_comb begin
    state_d   = state_q;
    respawn_d = 1'b0;
    lives_d   = lives_q;
    hold_d    = hold_q;
    mcnt_d    = mcnt_q;
    mouth_d   = mouth_q;
`ifdef ATTRACT_TIMEOUT_EN
    att_d     = att_q;
`endif

    if (state_q == S_PLAY) begin
      if (mcnt_q == MOUTH_W'(MOUTH_PERIOD - 1)) begin
        mcnt_d  = '0;
        mouth_d = ~mouth_q;
      end else begin
        mcnt_d = mcnt_q + MOUTH_W'(1);
      end
    end

    case (state_q)
      S_TITLE: begin
        if (press_c[0]) begin
          state_d   = S_PLAY;
          lives_d   = 2'(LIVES);
          respawn_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (dead_any_c) begin
          state_d = S_DEATH;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
          hold_d  = '0;
        end else if (press_c[1]) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press_c[1]) state_d = S_PLAY;
      end
      S_DEATH: begin
        if (hold_q == HOLD_W'(DEATH_HOLD_CYCLES - 1)) begin
          if (lives_q == 2'd0) begin
            state_d = S_GAMEOVER;
`ifdef ATTRACT_TIMEOUT_EN
            att_d   = '0;
`endif
          end else begin
            state_d   = S_PLAY;
            respawn_d = 1'b1;
          end
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_GAMEOVER: begin
        if (press_c[0]) begin
          state_d = S_TITLE;
`ifdef ATTRACT_TIMEOUT_EN
        end else if (att_q == ATT_W'(ATTRACT_CYCLES - 1)) begin
          state_d = S_TITLE;
        end else begin
          att_d = att_q + ATT_W'(1);
`endif
        end
      end
      default: state_d = S_TITLE;
    endcase

    // Respawn restarts the animation from a closed mouth.
    if (respawn_d) begin
      mcnt_d  = '0;
      mouth_d = 1'b0;
    end

    gameplay_d = (state_d == S_PLAY);
    stall_d    = (state_d != S_PLAY);
  end

  // State, synchronizer and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      dead_s1_q  <= '0;
      dead_s2_q  <= '0;
      init_q     <= '0;
      db_q       <= '0;
      db_cnt_q   <= '0;
      state_q    <= S_TITLE;
      gameplay_q <= 1'b0;
      stall_q    <= 1'b1;
      respawn_q  <= 1'b0;
      lives_q    <= 2'(LIVES);
      mouth_q    <= 1'b0;
      mcnt_q     <= '0;
      hold_q     <= '0;
`ifdef ATTRACT_TIMEOUT_EN
      att_q      <= '0;
`endif
    end else begin
      btn_s1_q   <= {pause_btn, start_btn};
      btn_s2_q   <= btn_s1_q;
      dead_s1_q  <= {player1_dead, player0_dead};
      dead_s2_q  <= dead_s1_q;
      init_q     <= init_d;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      gameplay_q <= gameplay_d;
      stall_q    <= stall_d;
      respawn_q  <= respawn_d;
      lives_q    <= lives_d;
      mouth_q    <= mouth_d;
      mcnt_q     <= mcnt_d;
      hold_q     <= hold_d;
`ifdef ATTRACT_TIMEOUT_EN
      att_q      <= att_d;
`endif
    end
  end

  assign screenReg    = state_q;
  assign gameplay     = gameplay_q;
  assign proc_stall   = stall_q;
  assign respawn      = respawn_q;
  assign lives_left   = lives_q;
  assign pacman_mouth = mouth_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with small timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_game_flow_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       start_btn, pause_btn, player0_dead, player1_dead;
  logic [2:0] screenReg;
  logic       gameplay, proc_stall, respawn, pacman_mouth;
  logic [1:0] lives_left;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES  (4),
    .DEATH_HOLD_CYCLES(8),
    .MOUTH_PERIOD     (5),
    .LIVES            (3)
`ifdef ATTRACT_TIMEOUT_EN
    , .ATTRACT_CYCLES (10)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start_btn   (start_btn),
    .pause_btn   (pause_btn),
    .player0_dead(player0_dead),
    .player1_dead(player1_dead),
    .screenReg   (screenReg),
    .gameplay    (gameplay),
    .proc_stall  (proc_stall),
    .respawn     (respawn),
    .lives_left  (lives_left),
    .pacman_mouth(pacman_mouth)
  );

  always #5 clock = ~clock;

  // Hard stop if the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_screen"},  8'(screenReg),    8'd0);
    chk({tag, "_gameplay"},8'(gameplay),     8'd0);
    chk({tag, "_stall"},   8'(proc_stall),   8'd1);
    chk({tag, "_respawn"}, 8'(respawn),      8'd0);
    chk({tag, "_lives"},   8'(lives_left),   8'd3);
    chk({tag, "_mouth"},   8'(pacman_mouth), 8'd0);
  endtask

  initial begin
    reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0;
    player0_dead = 1'b0; player1_dead = 1'b0;
    tick(3);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick(3);

    // Two-cycle start glitch never survives the debouncer.
    start_btn = 1'b1; tick(2); start_btn = 1'b0; tick(10);
    chk("glitch_screen", 8'(screenReg), 8'd0);

    // Held start: press accepted 6 cycles later (2 sync + 4 debounce). t counts from PLAY entry.
    start_btn = 1'b1; tick(5);
    chk("start_early", 8'(screenReg), 8'd0);
    tick(1); // t=0
    chk("start_screen",   8'(screenReg),  8'd1);
    chk("start_respawn",  8'(respawn),    8'd1);
    chk("start_gameplay", 8'(gameplay),   8'd1);
    chk("start_stall",    8'(proc_stall), 8'd0);
    chk("start_lives",    8'(lives_left), 8'd3);
    chk("start_mouth",    8'(pacman_mouth), 8'd0);
    tick(1); // t=1
    chk("respawn_one_cycle", 8'(respawn), 8'd0);
    tick(2); pause_btn = 1'b1;     // t=3
    tick(3); start_btn = 1'b0;     // t=6
    tick(2);                       // t=8
    chk("pause_early", 8'(screenReg), 8'd1);
    tick(1);                       // t=9: pause taken, mouth toggled at t=5
    chk("pause_screen",   8'(screenReg),    8'd2);
    chk("pause_stall",    8'(proc_stall),   8'd1);
    chk("pause_gameplay", 8'(gameplay),     8'd0);
    chk("pause_respawn",  8'(respawn),      8'd0);
    chk("pause_mouth",    8'(pacman_mouth), 8'd1);
    pause_btn = 1'b0;
    tick(11);                      // t=20: a running counter would have mouth=0 by now
    chk("pause_hold_screen", 8'(screenReg),    8'd2);
    chk("pause_mouth_frozen",8'(pacman_mouth), 8'd1);
    pause_btn = 1'b1;
    tick(5);                       // t=25
    chk("resume_early", 8'(screenReg), 8'd2);
    tick(1);                       // t=26
    chk("resume_screen",  8'(screenReg),    8'd1);
    chk("resume_respawn", 8'(respawn),      8'd0);
    chk("resume_stall",   8'(proc_stall),   8'd0);
    chk("resume_mouth",   8'(pacman_mouth), 8'd1);
    tick(1);                       // t=27: counter resumed at 4, wraps now
    chk("resume_mouth_wrap", 8'(pacman_mouth), 8'd0);
    pause_btn = 1'b0;

    // Death and pause arrive on the same cycle (pause 6-cycle path, dead 3-cycle path).
    tick(10); pause_btn = 1'b1;    // t=37
    tick(3);  player0_dead = 1'b1; // t=40
    tick(2);                       // t=42
    chk("death_early", 8'(screenReg), 8'd1);
    tick(1);                       // t=43
    chk("death_screen", 8'(screenReg),    8'd3);
    chk("death_lives",  8'(lives_left),   8'd2);
    chk("death_mouth",  8'(pacman_mouth), 8'd1);
    chk("death_stall",  8'(proc_stall),   8'd1);
    player0_dead = 1'b0; pause_btn = 1'b0;
    tick(7);                       // t=50
    chk("hold_last", 8'(screenReg), 8'd3);
    tick(1);                       // t=51
    chk("respawn_screen", 8'(screenReg),    8'd1);
    chk("respawn_pulse",  8'(respawn),      8'd1);
    chk("respawn_mouth",  8'(pacman_mouth), 8'd0);
    chk("respawn_lives",  8'(lives_left),   8'd2);
    tick(1);                       // t=52
    chk("respawn_drop", 8'(respawn), 8'd0);

    // Both players caught together cost a single life each time.
    player0_dead = 1'b1; player1_dead = 1'b1;
    tick(3);                       // t=55
    chk("death2_screen", 8'(screenReg),  8'd3);
    chk("death2_lives",  8'(lives_left), 8'd1);
    player0_dead = 1'b0; player1_dead = 1'b0;
    tick(8);                       // t=63
    chk("respawn2", 8'(respawn), 8'd1);
    tick(1);                       // t=64
    player0_dead = 1'b1; player1_dead = 1'b1;
    tick(3);                       // t=67
    chk("death3_screen", 8'(screenReg),  8'd3);
    chk("death3_lives",  8'(lives_left), 8'd0);
    player0_dead = 1'b0; player1_dead = 1'b0;
    tick(7);                       // t=74
    chk("death3_hold", 8'(screenReg), 8'd3);
    tick(1);                       // t=75
    chk("gameover_screen",  8'(screenReg),  8'd4);
    chk("gameover_respawn", 8'(respawn),    8'd0);
    chk("gameover_lives",   8'(lives_left), 8'd0);
    chk("gameover_stall",   8'(proc_stall), 8'd1);
    chk("gameover_play",    8'(gameplay),   8'd0);

`ifdef ATTRACT_TIMEOUT_EN
    tick(9);
    chk("attract_early", 8'(screenReg), 8'd4);
    tick(1);
    chk("attract_title", 8'(screenReg), 8'd0);
`else
    tick(100);
    chk("gameover_stays", 8'(screenReg), 8'd4);
    start_btn = 1'b1;
    tick(5);
    chk("gameover_start_early", 8'(screenReg), 8'd4);
    tick(1);
    chk("gameover_start_title", 8'(screenReg), 8'd0);
`endif
    start_btn = 1'b0;
    tick(10);

    // Pause has no effect on the title screen.
    pause_btn = 1'b1; tick(8);
    chk("title_pause_ignored", 8'(screenReg), 8'd0);
    pause_btn = 1'b0; tick(8);

    // New game reloads lives; mouth toggles every 5 PLAY cycles. k counts from PLAY entry.
    start_btn = 1'b1; tick(6);     // k=0
    chk("game2_screen",  8'(screenReg),  8'd1);
    chk("game2_lives",   8'(lives_left), 8'd3);
    chk("game2_respawn", 8'(respawn),    8'd1);
    tick(4);                       // k=4
    chk("mouth_k4", 8'(pacman_mouth), 8'd0);
    tick(1);                       // k=5
    chk("mouth_k5", 8'(pacman_mouth), 8'd1);
    tick(2); start_btn = 1'b0;     // k=7
    tick(3);                       // k=10
    chk("mouth_k10", 8'(pacman_mouth), 8'd0);
    tick(5);                       // k=15
    chk("mouth_k15", 8'(pacman_mouth), 8'd1);
    tick(2);                       // k=17, mouth counter mid-period

    // Asynchronous reset between clock edges, with start held through it.
    #2;
    reset = 1'b1; start_btn = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    tick(1);
    reset = 1'b0;
    tick(15);
    chk("held_through_reset", 8'(screenReg), 8'd0);
    start_btn = 1'b0;
    tick(10);
    start_btn = 1'b1;
    tick(5);
    chk("repress_early", 8'(screenReg), 8'd0);
    tick(1);
    chk("repress_screen",  8'(screenReg), 8'd1);
    chk("repress_respawn", 8'(respawn),   8'd1);
    start_btn = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
